// File: rtl/stream_prefetch_ctrl.sv
// Sequential-prefetch controller for the instruction-cache stream buffer: classifies
// L1 misses against the buffered stream, fetches next blocks, and sequences hit reads.
module stream_prefetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 4,
  parameter int T          = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENB,
  input  logic                  MISS_VALID,
  input  logic [ADDR_WIDTH-1:0] MISS_ADDR,
  output logic                  MISS_READY,
  output logic                  LOOKUP_DONE,
  output logic                  LOOKUP_HIT,
  output logic                  OUT_VALID,
  output logic [T-1:0]          OUT_SECTION,
  output logic                  MEM_REQ_VALID,
  input  logic                  MEM_REQ_READY,
  output logic [ADDR_WIDTH-1:0] MEM_REQ_ADDR,
  input  logic                  MEM_RESP_VALID,
  input  logic [WIDTH-1:0]      MEM_RESP_DATA,
  output logic                  SB_WR_ENB,
  output logic [WIDTH-1:0]      SB_DATA_IN,
  output logic                  SB_RD_ENB,
  output logic [T-1:0]          SB_SECTION_SEL,
  output logic                  SB_FLUSH,
  output logic [1:0]            LOOKUP_STATE,
  output logic [1:0]            PREFETCH_STATE
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_SERVE, L_FLUSH} lstate_t;
  typedef enum logic [1:0] {P_IDLE, P_REQ, P_FILL} pstate_t;

  lstate_t                 l_state, l_state_n;
  pstate_t                 p_state, p_state_n;
  logic                    active;
  logic [ADDR_WIDTH-1:0]   head_addr, next_addr, inflight_addr, miss_addr_q;
  logic [CW-1:0]           complete;
  logic                    inflight;
  logic [T-1:0]            beat_cnt;
  logic                    discard;
  logic [T:0]              serve_cnt;
  logic                    out_valid_q;
  logic [T-1:0]            out_section_q;

  logic miss_fire, mem_fire, beat, last_beat, fill_done;
  logic flush, pop, serve_end, start_req;

  // Valid/ready: a transfer happens on a rising edge where valid, ready and ENB are all
  // high; while ENB is high a raised valid keeps its payload stable until that edge.
  assign miss_fire = MISS_VALID & MISS_READY;
  assign mem_fire  = MEM_REQ_VALID & MEM_REQ_READY;
  assign beat      = ENB & MEM_RESP_VALID & (p_state == P_FILL);
  assign last_beat = beat & (beat_cnt == '1);
  assign fill_done = last_beat & ~discard;
  assign flush     = ENB & (l_state == L_FLUSH);
  assign pop       = ENB & (l_state == L_SERVE) & ~serve_cnt[T] & (serve_cnt[T-1:0] == '1);
  assign serve_end = (l_state == L_SERVE) & serve_cnt[T];
  // The flush cycle rewrites next_addr, so no request may be raised during it.
  assign start_req = active & ~inflight & (complete < CW'(DEPTH)) & (l_state != L_FLUSH);

  assign MISS_READY     = ENB & (l_state == L_IDLE);
  assign LOOKUP_DONE    = ENB & ((l_state == L_FLUSH) | serve_end);
  assign LOOKUP_HIT     = ENB & serve_end;
  assign SB_FLUSH       = flush;
  assign SB_RD_ENB      = pop;
  assign SB_SECTION_SEL = (l_state == L_SERVE) ? serve_cnt[T-1:0] : '0;
  assign SB_WR_ENB      = ENB & MEM_RESP_VALID & ~discard;
  assign SB_DATA_IN     = MEM_RESP_DATA;
  assign OUT_VALID      = out_valid_q;
  assign OUT_SECTION    = out_section_q;
  assign MEM_REQ_VALID  = ENB & ((p_state == P_REQ) | ((p_state == P_IDLE) & start_req));
  assign MEM_REQ_ADDR   = next_addr;
  assign LOOKUP_STATE   = l_state;
  assign PREFETCH_STATE = p_state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      l_state <= L_IDLE;
      p_state <= P_IDLE;
    end else if (ENB) begin
      l_state <= l_state_n;
      p_state <= p_state_n;
    end
  end

  always_comb begin
    l_state_n = l_state;
    case (l_state)
      L_IDLE: begin
        if (miss_fire) begin
          if (MISS_ADDR == head_addr && complete != '0)
            l_state_n = L_SERVE;
          else if (MISS_ADDR == head_addr && inflight && !discard && inflight_addr == head_addr)
            l_state_n = L_WAIT;
          else
            l_state_n = L_FLUSH;
        end
      end
      // complete!=0 covers a fill that finished in the very cycle the miss was classified.
      L_WAIT:  if (fill_done || complete != '0) l_state_n = L_SERVE;
      L_SERVE: if (serve_cnt[T]) l_state_n = L_IDLE;
      L_FLUSH: l_state_n = L_IDLE;
      default: l_state_n = L_IDLE;
    endcase
  end

  always_comb begin
    p_state_n = p_state;
    case (p_state)
      P_IDLE:  if (start_req) p_state_n = MEM_REQ_READY ? P_FILL : P_REQ;
      P_REQ:   if (MEM_REQ_READY) p_state_n = P_FILL;
      P_FILL:  if (last_beat) p_state_n = P_IDLE;
      default: p_state_n = P_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      active        <= 1'b0;
      head_addr     <= '0;
      next_addr     <= '0;
      inflight_addr <= '0;
      miss_addr_q   <= '0;
      complete      <= '0;
      inflight      <= 1'b0;
      beat_cnt      <= '0;
      discard       <= 1'b0;
      serve_cnt     <= '0;
      out_valid_q   <= 1'b0;
      out_section_q <= '0;
    end else if (ENB) begin
      if (miss_fire) miss_addr_q <= MISS_ADDR;

      serve_cnt     <= (l_state == L_SERVE) ? (serve_cnt[T] ? '0 : serve_cnt + 1'b1) : '0;
      out_valid_q   <= (l_state == L_SERVE) & ~serve_cnt[T];
      out_section_q <= serve_cnt[T-1:0];

      if (beat) beat_cnt <= beat_cnt + 1'b1;

      if (mem_fire) begin
        inflight      <= 1'b1;
        inflight_addr <= next_addr;
      end else if (last_beat) begin
        inflight <= 1'b0;
      end

      // A flush abandons whatever is requested or arriving; its beats are dropped.
      if (last_beat)
        discard <= 1'b0;
      else if (flush && (inflight || p_state == P_REQ))
        discard <= 1'b1;

      if (flush) begin
        active    <= 1'b1;
        head_addr <= miss_addr_q + 1'b1;
        next_addr <= miss_addr_q + 1'b1;
        complete  <= '0;
      end else begin
        if (mem_fire) next_addr <= next_addr + 1'b1;
        if (pop) head_addr <= head_addr + 1'b1;
        case ({fill_done, pop})
          2'b10:   complete <= complete + 1'b1;
          2'b01:   complete <= complete - 1'b1;
          default: complete <= complete;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// Directed bench for stream_prefetch_ctrl: memory responder with request scoreboard,
// cycle-exact checks of lookup, serve, flush, wrap and clock-enable behaviour.
module tb_stream_prefetch_ctrl;

  logic         clk, reset, enb;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready, lookup_done, lookup_hit, out_valid;
  logic [0:0]   out_section;
  logic         mem_req_valid, mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         sb_wr_enb, sb_rd_enb, sb_flush;
  logic [127:0] sb_data_in;
  logic [0:0]   sb_section_sel;
  logic [1:0]   lookup_state, prefetch_state;

  stream_prefetch_ctrl #(.ADDR_WIDTH(32), .WIDTH(128), .DEPTH(4), .T(1)) dut (
    .CLK(clk), .RESET(reset), .ENB(enb),
    .MISS_VALID(miss_valid), .MISS_ADDR(miss_addr), .MISS_READY(miss_ready),
    .LOOKUP_DONE(lookup_done), .LOOKUP_HIT(lookup_hit),
    .OUT_VALID(out_valid), .OUT_SECTION(out_section),
    .MEM_REQ_VALID(mem_req_valid), .MEM_REQ_READY(mem_req_ready), .MEM_REQ_ADDR(mem_req_addr),
    .MEM_RESP_VALID(mem_resp_valid), .MEM_RESP_DATA(mem_resp_data),
    .SB_WR_ENB(sb_wr_enb), .SB_DATA_IN(sb_data_in), .SB_RD_ENB(sb_rd_enb),
    .SB_SECTION_SEL(sb_section_sel), .SB_FLUSH(sb_flush),
    .LOOKUP_STATE(lookup_state), .PREFETCH_STATE(prefetch_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard of expected fetch addresses, in issue order
  logic [31:0] exp_q[$];
  int exp_total = 0;
  int req_total = 0;
  int wr_cnt    = 0;
  int drop_cnt  = 0;

  task automatic expect_req(input logic [31:0] a);
    exp_q.push_back(a);
    exp_total++;
  endtask

  // memory model: accepts every request, returns two beats after mem_lat idle cycles
  int mem_lat = 1;
  int mem_gap = 0;
  int resp_delay = 0, resp_beats = 0, resp_idx = 0;
  logic [31:0] resp_addr = '0;

  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (resp_beats > 0) begin
        if (resp_delay > 0) resp_delay--;
        else begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = {64'(resp_addr), 64'(resp_idx)};
          resp_idx++;
          resp_beats--;
          resp_delay = mem_gap;
        end
      end
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        req_total++;
        if (exp_q.size() == 0) check("req_count", req_total, exp_total);
        else check("req_addr", mem_req_addr, exp_q.pop_front());
        resp_addr  = mem_req_addr;
        resp_beats = 2;
        resp_idx   = 0;
        resp_delay = mem_lat;
      end
      if (sb_wr_enb) wr_cnt++;
      if (mem_resp_valid && !sb_wr_enb) drop_cnt++;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic miss(input logic [31:0] a);
    miss_valid = 1'b1;
    miss_addr  = a;
    neg();
    check("miss_ready", miss_ready, 1);
    cyc();
    miss_valid = 1'b0;
  endtask

  task automatic expect_serve(input string tag);
    neg();
    check({tag, "_sel0"}, sb_section_sel, 0);
    check({tag, "_rd0"}, sb_rd_enb, 0);
    check({tag, "_ov0"}, out_valid, 0);
    cyc(); neg();
    check({tag, "_sel1"}, sb_section_sel, 1);
    check({tag, "_rd1"}, sb_rd_enb, 1);
    check({tag, "_ov1"}, out_valid, 1);
    check({tag, "_osec0"}, out_section, 0);
    cyc(); neg();
    check({tag, "_done"}, lookup_done, 1);
    check({tag, "_hit"}, lookup_hit, 1);
    check({tag, "_ov2"}, out_valid, 1);
    check({tag, "_osec1"}, out_section, 1);
    cyc(); neg();
    check({tag, "_ready"}, miss_ready, 1);
    check({tag, "_ov3"}, out_valid, 0);
    cyc();
  endtask

  task automatic settle(input string tag, input int max_cycles);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      neg();
      if (exp_q.size() == 0 && resp_beats == 0 && prefetch_state == 2'd0 && lookup_state == 2'd0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check({tag, "_settled"}, ok, 1);
    repeat (6) cyc();
  endtask

  int wr0, drop0, req0;
  logic found;

  initial begin
    reset = 1'b1; enb = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_ready_init();
    cyc(); neg();
    check("rst_miss_ready", miss_ready, 1);
    check("rst_done", lookup_done, 0);
    check("rst_flush", sb_flush, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd", sb_rd_enb, 0);
    check("rst_wr", sb_wr_enb, 0);
    check("rst_lstate", lookup_state, 0);
    check("rst_pstate", prefetch_state, 0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    neg();
    check("idle_no_req", mem_req_valid, 0);
    cyc();

    // cold miss
    wr0 = wr_cnt; req0 = req_total;
    for (int i = 1; i <= 4; i++) expect_req(32'h100 + i);
    miss(32'h100);
    neg();
    check("cold_done", lookup_done, 1);
    check("cold_hit", lookup_hit, 0);
    check("cold_flush", sb_flush, 1);
    check("cold_req_early", mem_req_valid, 0);
    cyc(); neg();
    check("cold_req_valid", mem_req_valid, 1);
    check("cold_req_addr", mem_req_addr, 32'h101);
    cyc();
    settle("cold", 100);
    check("cold_reqs", req_total - req0, 4);
    check("cold_writes", wr_cnt - wr0, 8);

    // sequential hit
    expect_req(32'h105);
    miss(32'h101);
    expect_serve("hit101");
    settle("hit101", 50);

    // wait path
    for (int i = 1; i <= 5; i++) expect_req(32'h200 + i);
    miss(32'h200);
    neg();
    check("wait_flush", sb_flush, 1);
    cyc();
    cyc();
    miss(32'h201);
    neg();
    check("wait_no_done1", lookup_done, 0);
    check("wait_lstate", lookup_state, 1);
    cyc(); neg();
    check("wait_no_done2", lookup_done, 0);
    check("wait_last_beat_wr", sb_wr_enb, 1);
    cyc();
    expect_serve("wait201");
    settle("wait", 100);

    // flush with discard
    mem_gap = 3;
    expect_req(32'h206);
    miss(32'h202);
    expect_serve("hit202");
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      neg();
      if (mem_resp_valid && sb_wr_enb) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("disc_first_beat", found, 1);
    cyc();
    wr0 = wr_cnt; drop0 = drop_cnt;
    mem_gap = 0;
    for (int i = 1; i <= 4; i++) expect_req(32'h300 + i);
    miss(32'h300);
    neg();
    check("disc_flush", sb_flush, 1);
    check("disc_hit", lookup_hit, 0);
    cyc();
    settle("disc", 100);
    check("disc_dropped", drop_cnt - drop0, 1);
    check("disc_writes", wr_cnt - wr0, 8);

    // address wrap
    expect_req(32'hFFFF_FFFF);
    expect_req(32'h0);
    expect_req(32'h1);
    expect_req(32'h2);
    miss(32'hFFFF_FFFE);
    neg();
    check("wrap_flush", sb_flush, 1);
    cyc();
    settle("wrap", 100);
    expect_req(32'h3);
    miss(32'hFFFF_FFFF);
    expect_serve("wrap_hit_ff");
    expect_req(32'h4);
    miss(32'h0);
    expect_serve("wrap_hit_0");
    settle("wrap_hits", 100);

    // clock enable low mid-serve
    expect_req(32'h5);
    miss(32'h1);
    neg();
    check("enb_sel0", sb_section_sel, 0);
    check("enb_ov0", out_valid, 0);
    cyc();
    enb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      neg();
      check("enb_frz_sel", sb_section_sel, 1);
      check("enb_frz_rd", sb_rd_enb, 0);
      check("enb_frz_ov", out_valid, 1);
      check("enb_frz_osec", out_section, 0);
      check("enb_frz_done", lookup_done, 0);
      cyc();
    end
    enb = 1'b1;
    neg();
    check("enb_res_sel", sb_section_sel, 1);
    check("enb_res_rd", sb_rd_enb, 1);
    check("enb_res_osec", out_section, 0);
    cyc(); neg();
    check("enb_res_done", lookup_done, 1);
    check("enb_res_hit", lookup_hit, 1);
    check("enb_res_osec1", out_section, 1);
    cyc(); neg();
    check("enb_res_ready", miss_ready, 1);
    cyc();
    settle("enb", 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic mem_ready_init();
    mem_req_ready = 1'b1;
  endtask

endmodule
